// File: rtl/wt_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wt_cache_pkg
// Description : Shared types for the write-through cache SPM way
//               initialiser: the init FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package wt_cache_pkg;

    // Init sequencer states. CHECK and DRAIN are reachable only when the
    // readback option is built in.
    typedef enum logic [1:0] {
        SPM_IDLE  = 2'd0,
        SPM_CLEAR = 2'd1,
        SPM_CHECK = 2'd2,
        SPM_DRAIN = 2'd3
    } spm_init_state_t;

endpackage
`default_nettype wire

// File: rtl/spm_way_init_if.sv
`default_nettype none
// ============================================================================
// Module      : spm_way_init_if
// Description : Bundle of per-way control, client and SRAM-port signals of
//               the SPM way initialiser. slave = initialiser side,
//               master = surrounding cache / SRAM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface spm_way_init_if #(
    parameter int NR_WAYS      = 4,
    parameter int MEMORY_WIDTH = 173,
    parameter int ADDR_WIDTH   = 64
);
    localparam int BE_WIDTH = (MEMORY_WIDTH + 7) / 8;

    // way control / status
    logic [NR_WAYS-1:0]                     active_ways_i;
    logic [NR_WAYS-1:0]                     ways_ready_o;
    logic                                   busy_o;
    logic [NR_WAYS-1:0]                     err_o;

    // client side
    logic [NR_WAYS-1:0]                     cl_req_i;
    logic [NR_WAYS-1:0][ADDR_WIDTH-1:0]     cl_addr_i;
    logic [NR_WAYS-1:0]                     cl_we_i;
    logic [NR_WAYS-1:0][MEMORY_WIDTH-1:0]   cl_wdata_i;
    logic [NR_WAYS-1:0][BE_WIDTH-1:0]       cl_be_i;
    logic [NR_WAYS-1:0]                     cl_gnt_o;

    // way SRAM side
    logic [NR_WAYS-1:0]                     req_o;
    logic [NR_WAYS-1:0][ADDR_WIDTH-1:0]     addr_o;
    logic [NR_WAYS-1:0][MEMORY_WIDTH-1:0]   wdata_o;
    logic [NR_WAYS-1:0]                     we_o;
    logic [NR_WAYS-1:0][BE_WIDTH-1:0]       be_o;
    logic [NR_WAYS-1:0][MEMORY_WIDTH-1:0]   rdata_i;

    modport slave (
        input  active_ways_i, cl_req_i, cl_addr_i, cl_we_i, cl_wdata_i, cl_be_i, rdata_i,
        output ways_ready_o, busy_o, err_o, cl_gnt_o, req_o, addr_o, wdata_o, we_o, be_o
    );

    modport master (
        output active_ways_i, cl_req_i, cl_addr_i, cl_we_i, cl_wdata_i, cl_be_i, rdata_i,
        input  ways_ready_o, busy_o, err_o, cl_gnt_o, req_o, addr_o, wdata_o, we_o, be_o
    );

endinterface
`default_nettype wire

// File: rtl/spm_way_init.sv
`default_nettype none
// ============================================================================
// Module      : spm_way_init
// Description : Zero-initialises cache ways switched into scratchpad mode.
//               Newly activated ways are queued, cleared one at a time
//               (lowest index first) and then released to clients. While a
//               way is being cleared its SRAM port is owned by the
//               initialiser; all other ways pass client traffic through,
//               gated by their ready bit.
//               Optional macro SPM_INIT_READBACK_EN adds a read-back pass
//               that flags any nonzero word in err_o.
// Revision    : 1.0 - initial release
// ============================================================================
module spm_way_init
    import wt_cache_pkg::*;
#(
    parameter int NR_WAYS      = 4,
    parameter int NR_LINES     = 256,
    parameter int MEMORY_WIDTH = 173,
    parameter int ADDR_WIDTH   = 64
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    spm_way_init_if.slave   bus
);

    localparam int unsigned c_cnt_w = $clog2(NR_LINES);
    localparam int unsigned c_way_w = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;
    localparam int unsigned c_be_w  = (MEMORY_WIDTH + 7) / 8;

    spm_init_state_t        r_state;
    spm_init_state_t        w_state_nxt;
    logic [NR_WAYS-1:0]     r_active_q;
    logic [NR_WAYS-1:0]     r_pending;
    logic [NR_WAYS-1:0]     r_ready;
    logic [NR_WAYS-1:0]     w_err;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic [c_way_w-1:0]     r_cur_way;
    logic [c_way_w-1:0]     w_cur_way_nxt;

    logic [NR_WAYS-1:0]     w_rise;
    logic [NR_WAYS-1:0]     w_fall;
    logic                   w_abort;
    logic                   w_last;
    logic                   w_pick_found;
    logic [c_way_w-1:0]     w_pick_idx;
    logic [NR_WAYS-1:0]     w_pick_clr;
    logic [NR_WAYS-1:0]     w_ready_set;

    assign w_rise  = bus.active_ways_i & ~r_active_q;
    assign w_fall  = r_active_q & ~bus.active_ways_i;
    // Losing the way currently being initialised cancels the whole job.
    assign w_abort = (r_state != SPM_IDLE) && w_fall[r_cur_way];
    assign w_last  = (r_cnt == c_cnt_w'(NR_LINES - 1));

    // Lowest-index pending way; scanning downward lets the lowest hit win.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        for (int i = NR_WAYS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = c_way_w'(i);
            end
        end
    end

    // Next-state, line counter and completion decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cur_way_nxt = r_cur_way;
        w_pick_clr    = '0;
        w_ready_set   = '0;
        case (r_state)
            SPM_IDLE: begin
                if (w_pick_found) begin
                    w_cur_way_nxt          = w_pick_idx;
                    w_pick_clr[w_pick_idx] = 1'b1;
                    w_cnt_nxt              = '0;
                    w_state_nxt            = SPM_CLEAR;
                end
            end
            SPM_CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_last) begin
`ifdef SPM_INIT_READBACK_EN
                    w_state_nxt = SPM_CHECK;
`else
                    w_state_nxt            = SPM_IDLE;
                    w_ready_set[r_cur_way] = 1'b1;
`endif
                end
            end
`ifdef SPM_INIT_READBACK_EN
            SPM_CHECK: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_last) begin
                    // Ready becomes visible in DRAIN while the last word is compared.
                    w_state_nxt            = SPM_DRAIN;
                    w_ready_set[r_cur_way] = 1'b1;
                end
            end
            SPM_DRAIN: begin
                w_state_nxt = SPM_IDLE;
            end
`endif
            default: begin
                w_state_nxt = SPM_IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_nxt = SPM_IDLE;
            w_cnt_nxt   = '0;
            w_ready_set = '0;
        end
    end

    // State, bookkeeping and per-way status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= SPM_IDLE;
            r_active_q <= '0;
            r_pending  <= '0;
            r_ready    <= '0;
            r_cnt      <= '0;
            r_cur_way  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_active_q <= bus.active_ways_i;
            r_pending  <= (r_pending & ~w_pick_clr & ~w_fall) | w_rise;
            r_ready    <= (r_ready | w_ready_set) & ~w_fall;
            r_cnt      <= w_cnt_nxt;
            r_cur_way  <= w_cur_way_nxt;
        end
    end

`ifdef SPM_INIT_READBACK_EN
    logic                   r_rd_vld;
    logic [NR_WAYS-1:0]     r_err;
    logic [NR_WAYS-1:0]     w_err_set;

    // A read issued in CHECK returns data one cycle later; flag any nonzero word.
    always_comb begin
        w_err_set = '0;
        if (r_rd_vld && !w_abort && (bus.rdata_i[r_cur_way] != '0)) begin
            w_err_set[r_cur_way] = 1'b1;
        end
    end

    // Sticky error bits, cleared only by deactivating the way.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_vld <= 1'b0;
            r_err    <= '0;
        end else begin
            r_rd_vld <= (r_state == SPM_CHECK) && !w_abort;
            r_err    <= (r_err | w_err_set) & ~w_fall;
        end
    end

    assign w_err = r_err;
`else
    logic w_unused_rdata;

    assign w_err          = '0;
    assign w_unused_rdata = ^bus.rdata_i;
`endif

    // SRAM port mux: the way under init is owned by the sequencer, all
    // others see client traffic gated by their ready bit.
    always_comb begin
        bus.req_o    = '0;
        bus.cl_gnt_o = '0;
        bus.addr_o   = bus.cl_addr_i;
        bus.wdata_o  = bus.cl_wdata_i;
        bus.we_o     = bus.cl_we_i;
        bus.be_o     = bus.cl_be_i;
        for (int w = 0; w < NR_WAYS; w++) begin
            if (((r_state == SPM_CLEAR) || (r_state == SPM_CHECK)) &&
                (r_cur_way == c_way_w'(w))) begin
                bus.req_o[w]   = 1'b1;
                bus.addr_o[w]  = ADDR_WIDTH'(r_cnt);
                bus.wdata_o[w] = '0;
                bus.we_o[w]    = (r_state == SPM_CLEAR);
                bus.be_o[w]    = {c_be_w{1'b1}};
            end else begin
                bus.req_o[w]    = bus.cl_req_i[w] & r_ready[w];
                bus.cl_gnt_o[w] = bus.cl_req_i[w] & r_ready[w];
            end
        end
    end

    assign bus.ways_ready_o = r_ready;
    assign bus.err_o        = w_err;
    assign bus.busy_o       = (r_state != SPM_IDLE) || (r_pending != '0);

endmodule
`default_nettype wire

// File: tb/tb_spm_way_init.sv
`default_nettype none
// ============================================================================
// Module      : tb_spm_way_init
// Description : Self-checking bench for spm_way_init. A job-level reference
//               model (pending set, one running job with phase/address)
//               predicts every output each cycle; directed scenarios add
//               explicit timing checks, followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spm_way_init;

    localparam int NR_WAYS      = 4;
    localparam int NR_LINES     = 256;
    localparam int MEMORY_WIDTH = 173;
    localparam int ADDR_WIDTH   = 64;
    localparam int BE_W         = (MEMORY_WIDTH + 7) / 8;
`ifdef SPM_INIT_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spm_way_init_if #(.NR_WAYS(NR_WAYS), .MEMORY_WIDTH(MEMORY_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    spm_way_init #(
        .NR_WAYS(NR_WAYS), .NR_LINES(NR_LINES),
        .MEMORY_WIDTH(MEMORY_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    // staged stimulus, applied on each falling edge
    logic                                 s_rst;
    logic [NR_WAYS-1:0]                   s_act, s_req, s_we;
    logic [NR_WAYS-1:0][ADDR_WIDTH-1:0]   s_addr;
    logic [NR_WAYS-1:0][MEMORY_WIDTH-1:0] s_wdata, s_rdata;
    logic [NR_WAYS-1:0][BE_W-1:0]         s_be;

    // read-error injection
    bit inj_en;
    int inj_way, inj_addr;

    // reference model
    logic [NR_WAYS-1:0] m_act, m_pend, m_ready, m_err;
    bit m_job, m_rd;
    int m_way, m_addr, m_phase;   // phase 0 = zero-fill, 1 = readback, 2 = drain

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [703:0] got, input logic [703:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [MEMORY_WIDTH-1:0] rand_word();
        logic [191:0] r;
        for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
        return r[MEMORY_WIDTH-1:0];
    endfunction

    task automatic model_reset();
        m_act = '0; m_pend = '0; m_ready = '0; m_err = '0;
        m_job = 0; m_rd = 0; m_way = 0; m_addr = 0; m_phase = 0;
    endtask

    // Expected outputs for the current model state and current inputs.
    task automatic compare_all();
        logic [NR_WAYS-1:0]                   e_req, e_gnt, e_we;
        logic [NR_WAYS-1:0][ADDR_WIDTH-1:0]   e_addr;
        logic [NR_WAYS-1:0][MEMORY_WIDTH-1:0] e_wdata;
        logic [NR_WAYS-1:0][BE_W-1:0]         e_be;
        for (int w = 0; w < NR_WAYS; w++) begin
            if (m_job && w == m_way && m_phase < 2) begin
                e_req[w]   = 1'b1;
                e_gnt[w]   = 1'b0;
                e_addr[w]  = ADDR_WIDTH'(m_addr);
                e_we[w]    = (m_phase == 0);
                e_wdata[w] = '0;
                e_be[w]    = '1;
            end else begin
                e_req[w]   = s_req[w] && m_ready[w];
                e_gnt[w]   = s_req[w] && m_ready[w];
                e_addr[w]  = s_addr[w];
                e_we[w]    = s_we[w];
                e_wdata[w] = s_wdata[w];
                e_be[w]    = s_be[w];
            end
        end
        check("req_o",   704'(bus.req_o),        704'(e_req));
        check("cl_gnt",  704'(bus.cl_gnt_o),     704'(e_gnt));
        check("addr_o",  704'(bus.addr_o),       704'(e_addr));
        check("we_o",    704'(bus.we_o),         704'(e_we));
        check("wdata_o", 704'(bus.wdata_o),      704'(e_wdata));
        check("be_o",    704'(bus.be_o),         704'(e_be));
        check("ready",   704'(bus.ways_ready_o), 704'(m_ready));
        check("busy",    704'(bus.busy_o),       704'(m_job || (m_pend != '0)));
        check("err",     704'(bus.err_o),        704'(m_err));
    endtask

    // Advance the model across one rising edge with the inputs of this cycle.
    task automatic model_step();
        logic [NR_WAYS-1:0] rise, fall, set_err;
        bit abort, nrd;
        rise    = s_act & ~m_act;
        fall    = m_act & ~s_act;
        abort   = m_job && fall[m_way];
        set_err = '0;
        if (RB && m_rd && !abort && s_rdata[m_way] != '0) set_err[m_way] = 1'b1;
        nrd = m_job && m_phase == 1 && !abort;
        if (!m_job) begin
            for (int i = 0; i < NR_WAYS; i++) begin
                if (m_pend[i]) begin
                    m_job = 1; m_way = i; m_addr = 0; m_phase = 0; m_pend[i] = 1'b0;
                    break;
                end
            end
        end else if (abort) begin
            m_job = 0;
        end else if (m_phase == 2) begin
            m_job = 0;
        end else if (m_addr == NR_LINES - 1) begin
            m_addr = 0;
            if (m_phase == 0 && !RB) begin
                m_job = 0; m_ready[m_way] = 1'b1;
            end else if (m_phase == 0) begin
                m_phase = 1;
            end else begin
                m_phase = 2; m_ready[m_way] = 1'b1;
            end
        end else begin
            m_addr++;
        end
        m_pend  = (m_pend & ~fall) | rise;
        m_ready = m_ready & ~fall;
        m_err   = (m_err | set_err) & ~fall;
        m_act   = s_act;
        m_rd    = nrd;
    endtask

    // One clock cycle: apply staged inputs, check, advance the model.
    task automatic step();
        @(negedge clk);
        cyc++;
        rst               = s_rst;
        bus.active_ways_i = s_act;
        bus.cl_req_i      = s_req;
        bus.cl_addr_i     = s_addr;
        bus.cl_we_i       = s_we;
        bus.cl_wdata_i    = s_wdata;
        bus.cl_be_i       = s_be;
        bus.rdata_i       = s_rdata;
        if (s_rst) model_reset();
        #1;
        compare_all();
        if (!s_rst) model_step();
        for (int w = 0; w < NR_WAYS; w++) begin
            s_rdata[w] = (inj_en && w == inj_way && bus.req_o[w] && !bus.we_o[w] &&
                          bus.addr_o[w] == ADDR_WIDTH'(inj_addr)) ? MEMORY_WIDTH'(1) : '0;
        end
    endtask

    task automatic randomize_clients();
        for (int w = 0; w < NR_WAYS; w++) begin
            s_addr[w]  = {$urandom, $urandom};
            s_wdata[w] = rand_word();
            s_be[w]    = BE_W'({$urandom, $urandom, $urandom});
        end
        s_req = NR_WAYS'($urandom);
        s_we  = NR_WAYS'($urandom);
    endtask

    initial begin
        model_reset();
        inj_en = 0; inj_way = 0; inj_addr = 0;
        s_rst = 1'b1; s_act = 4'b0001; s_req = '0; s_we = '0;
        s_addr = '0; s_wdata = '0; s_rdata = '0; s_be = '0;
        rst = 1'b1;

        // reset with way0 already active: it must be initialised after release
        repeat (3) step();
        check("rst_ready", 704'(bus.ways_ready_o), 704'(0));
        check("rst_req",   704'(bus.req_o),        704'(0));
        s_rst = 1'b0;
        repeat (NR_LINES * (RB ? 2 : 1) + 6) step();
        check("w0_ready", 704'(bus.ways_ready_o[0]), 704'(1));

        // way3 activation: zero writes at t+2..t+257, then ready
        s_act = 4'b1001;
        step();                     // cycle t
        step(); step();             // t+1, t+2
        check("w3_first_wr", 704'({bus.req_o[3], bus.we_o[3], bus.addr_o[3]}), 704'({2'b11, 64'd0}));
        repeat (NR_LINES - 1) step();   // t+257
        check("w3_last_wr", 704'({bus.req_o[3], bus.we_o[3], bus.addr_o[3]}), 704'({2'b11, 64'd255}));
        check("w3_not_rdy", 704'(bus.ways_ready_o[3]), 704'(0));
`ifdef SPM_INIT_READBACK_EN
        repeat (NR_LINES) step();       // t+513, last read
        check("w3_rd_not_rdy", 704'(bus.ways_ready_o[3]), 704'(0));
`endif
        step();
        check("w3_rdy", 704'(bus.ways_ready_o[3]), 704'(1));
        step();

        // way0 ready, way1 clearing, clients on ways 0 and 1
        s_act = 4'b1011;
        repeat (6) step();
        randomize_clients();
        s_req = 4'b0011;
        step();
        check("gnt_mix", 704'(bus.cl_gnt_o), 704'(4'b0001));
        check("w1_init_wr", 704'({bus.we_o[1], bus.wdata_o[1]}), 704'({1'b1, 173'd0}));
        repeat (NR_LINES * (RB ? 2 : 1)) begin
            randomize_clients();
            step();
        end
        s_req = '0;

        // deactivate way1 while zero-filling address 100
        s_act = 4'b0000;
        repeat (3) step();
        s_act = 4'b0010;
        step();                     // t
        repeat (101) step();        // t+101
        s_act = 4'b0000;
        step();                     // t+102: write to addr 100
        check("abort_wr100", 704'({bus.req_o[1], bus.addr_o[1]}), 704'({1'b1, 64'd100}));
        step();                     // t+103
        check("abort_no101", 704'(bus.req_o[1]), 704'(0));
        check("abort_busy",  704'(bus.busy_o), 704'(0));
        check("abort_rdy",   704'(bus.ways_ready_o[1]), 704'(0));

        // two ways at once: lowest first, second starts after one idle cycle
        s_act = 4'b0110;
        step();                     // t
        repeat (NR_LINES * (RB ? 2 : 1) + 1) step();
`ifndef SPM_INIT_READBACK_EN
        // now at t+257: way1 last write, way2 still waiting
        check("two_w2_wait", 704'(bus.req_o[2]), 704'(0));
        step();                     // t+258: idle pick cycle
        check("two_gap", 704'({bus.req_o[2], bus.busy_o}), 704'({1'b0, 1'b1}));
        step();                     // t+259
        check("two_w2_first", 704'({bus.req_o[2], bus.addr_o[2]}), 704'({1'b1, 64'd0}));
        repeat (NR_LINES) step();   // t+515
        check("two_w2_rdy", 704'(bus.ways_ready_o[2]), 704'(1));
`else
        repeat (NR_LINES * 2 + 4) step();
`endif

        // re-activation while pending leaves a single pending job
        s_act = 4'b0000;
        repeat (3) step();
        s_act = 4'b0011;
        repeat (10) step();
        s_act = 4'b0001;
        step();
        s_act = 4'b0011;
        repeat (NR_LINES * (RB ? 4 : 2) + 8) step();
        check("react_rdy", 704'(bus.ways_ready_o), 704'(4'b0011));

`ifdef SPM_INIT_READBACK_EN
        // readback error on address 5 of way2
        s_act = 4'b0000;
        repeat (3) step();
        inj_en = 1; inj_way = 2; inj_addr = 5;
        s_act = 4'b0100;
        repeat (NR_LINES * 2 + 5) step();
        inj_en = 0;
        check("rb_err",  704'(bus.err_o[2]), 704'(1));
        check("rb_rdy",  704'(bus.ways_ready_o[2]), 704'(1));
        repeat (20) step();
        check("rb_sticky", 704'(bus.err_o[2]), 704'(1));
        s_act = 4'b0000;
        step(); step();
        check("rb_clr", 704'(bus.err_o[2]), 704'(0));
`endif

        // mid-operation reset, ways stay active and restart afterwards
        s_act = 4'b0101;
        repeat (40) step();
        s_rst = 1'b1;
        step();
        check("midrst_req", 704'(bus.req_o), 704'(0));
        s_rst = 1'b0;

        // randomized activation changes, client traffic and occasional reset
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 299) == 0) s_act[$urandom_range(0, NR_WAYS - 1)] ^= 1'b1;
            randomize_clients();
            s_rst = ($urandom_range(0, 1999) == 0);
            step();
        end
        s_rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
